pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage RV32I pipeline. Drives the en/flush

---
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data-memory wait states,
// taken-branch redirect bubbles and load-use interlock, plus stall counter and timeout flag.
module pipeline_hazard_ctrl #(
    parameter int REDIRECT_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_val,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);
    localparam logic [3:0] REDIR_LD = 4'(REDIRECT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic [3:0]  redir_cnt, redir_cnt_nxt;
    logic        mem_err_nxt;
    logic [4:0]  en_c;          // {pc, ifid, idex, exmem, memwb}
    logic        ifid_fl_c, idex_fl_c;
    logic        mem_stall, load_use, frozen;

    assign mem_stall = mem_val & ~dmem_ready;
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    // In MEM_WAIT the pipeline stays frozen until memory answers, regardless of mem_val.
    assign frozen    = (state == MEM_WAIT) ? ~dmem_ready : mem_stall;

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        redir_cnt_nxt = redir_cnt;
        en_c          = 5'b11111;
        ifid_fl_c     = 1'b0;
        idex_fl_c     = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (frozen) begin
                    en_c      = 5'b00000;
                    state_nxt = MEM_WAIT;
                    if (state == RUN)
                        wait_cnt_nxt = 8'd1;
                    else if (wait_cnt != TIMEOUT)
                        wait_cnt_nxt = wait_cnt + 8'd1;
                end else if (ex_branch_taken) begin
                    ifid_fl_c = 1'b1;
                    idex_fl_c = 1'b1;
                    if (REDIRECT_CYCLES > 1) begin
                        state_nxt     = REDIRECT;
                        redir_cnt_nxt = REDIR_LD;
                    end else begin
                        state_nxt = RUN;
                    end
                end else if (load_use) begin
                    en_c      = 5'b00111;
                    idex_fl_c = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = RUN;
                end
            end
            REDIRECT: begin
                if (mem_stall) begin
                    // Memory wait wins; leftover redirect bubbles are abandoned.
                    en_c          = 5'b00000;
                    state_nxt     = MEM_WAIT;
                    wait_cnt_nxt  = 8'd1;
                    redir_cnt_nxt = 4'd0;
                end else begin
                    ifid_fl_c     = 1'b1;
                    redir_cnt_nxt = redir_cnt - 4'd1;
                    if (redir_cnt <= 4'd1)
                        state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        mem_err_nxt = mem_err | ((state_nxt == MEM_WAIT) && (wait_cnt_nxt == TIMEOUT));
    end

    assign pc_en      = rst & en_c[4];
    assign ifid_en    = rst & en_c[3];
    assign idex_en    = rst & en_c[2];
    assign exmem_en   = rst & en_c[1];
    assign memwb_en   = rst & en_c[0];
    assign ifid_flush = rst & ifid_fl_c;
    assign idex_flush = rst & idex_fl_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            redir_cnt    <= 4'd0;
            mem_err      <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            redir_cnt <= redir_cnt_nxt;
            mem_err   <= mem_err_nxt;
            if (!pc_en)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

    localparam int R = 3;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_val, dmem_ready;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_err;
    logic [31:0] stall_cycles;

    pipeline_hazard_ctrl #(.REDIRECT_CYCLES(R), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_val(mem_val), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: waiting on memory?, how long, redirect bubbles still owed, sticky error, stall count.
    bit          m_wait;
    int          m_waited;
    int          m_bub;
    bit          m_err;
    logic [31:0] m_stall;
    logic [6:0]  last_o;   // {pc, ifid, ifid_fl, idex, idex_fl, exmem, memwb}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_waited = 0; m_bub = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_val = 0; dmem_ready = 1;
    endtask

    // One clock: check outputs at the negedge against the model, then advance the model.
    task automatic step();
        logic [6:0] e;
        bit freeze, tail, first, lu;
        @(negedge clk);
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        freeze = m_wait ? !dmem_ready : (mem_val && !dmem_ready);
        tail   = !freeze && !m_wait && m_bub > 0;
        first  = !freeze && !tail && ex_branch_taken;
        if (!rst) begin
            model_reset();
            e = 7'b0;
        end else if (freeze)    e = 7'b0000000;
        else if (tail)          e = 7'b1111011;
        else if (first)         e = 7'b1111111;
        else if (lu)            e = 7'b0001111;
        else                    e = 7'b1101011;
        last_o = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};
        chk("en_flush", 32'(last_o), 32'(e));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        chk("stall_cycles", stall_cycles, m_stall);
        if (rst) begin
            if (!e[6]) m_stall = m_stall + 1;
            if (freeze) begin
                m_waited = m_wait ? ((m_waited < T) ? m_waited + 1 : T) : 1;
                m_wait   = 1;
                m_bub    = 0;
                if (m_waited == T) m_err = 1;
            end else begin
                m_wait = 0;
                if (tail)  m_bub = m_bub - 1;
                if (first) m_bub = R - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int          fl_cnt, idfl_cnt;
    logic [31:0] s0;

    initial begin
        idle();
        rst = 0;
        model_reset();
        #12;
        chk("reset_outs", 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_err}), 32'd0);
        chk("reset_stall", stall_cycles, 32'd0);
        @(posedge clk); #1;
        rst = 1;
        step(); step();

        // T2 load-use on rs2
        s0 = stall_cycles;
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        step();
        chk("T2_bubble", 32'(last_o), 32'(7'b0001111));
        idle(); step();
        chk("T2_stall", stall_cycles - s0, 32'd1);

        // T3 load to x0 never interlocks
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
        step();
        chk("T3_pc_en", 32'(last_o[6]), 32'd1);
        idle();

        // T4 three wait states, released on the fourth cycle
        s0 = stall_cycles;
        mem_val = 1; dmem_ready = 0;
        repeat (3) step();
        dmem_ready = 1;
        step();
        chk("T4_release", 32'(last_o), 32'(7'b1101011));
        chk("T4_stall", stall_cycles - s0, 32'd3);
        idle();

        // T5 taken branch with three redirect cycles
        fl_cnt = 0; idfl_cnt = 0;
        ex_branch_taken = 1;
        step();
        fl_cnt += last_o[4]; idfl_cnt += last_o[2];
        ex_branch_taken = 0;
        repeat (3) begin
            step();
            fl_cnt += last_o[4]; idfl_cnt += last_o[2];
        end
        chk("T5_ifid_flush_cycles", 32'(fl_cnt), 32'd3);
        chk("T5_idex_flush_cycles", 32'(idfl_cnt), 32'd1);

        // T6 timeout sets a sticky error
        mem_val = 1; dmem_ready = 0;
        repeat (3) step();
        chk("T6_before", 32'(mem_err), 32'd0);
        repeat (3) step();
        idle();
        step(); step();
        chk("T6_sticky", 32'(mem_err), 32'd1);

        // T1 async reset in the middle of a wait
        mem_val = 1; dmem_ready = 0;
        repeat (5) step();
        #2;
        rst = 0;
        #1;
        chk("T1_outs", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, mem_err}), 32'd0);
        chk("T1_stall", stall_cycles, 32'd0);
        model_reset();
        step();
        idle();
        rst = 1;
        step();
        chk("T1_run", 32'(last_o), 32'(7'b1101011));

        // Random traffic
        repeat (3000) begin
            rst             = ($urandom_range(0, 199) != 0);
            mem_val         = ($urandom_range(0, 9) < 3);
            dmem_ready      = ($urandom_range(0, 9) < 6);
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            ex_mem_read     = ($urandom_range(0, 9) < 4);
            ex_rd           = 5'($urandom_range(0, 3));
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
